// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - state_t    : arbiter FSM encoding (2 bits)
//   - ID_IC/ID_DC: requester identifiers used for grant_id / last_grant
//   - ADDR_W_DEF / LINE_W_DEF : default line-address and line widths
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic ID_IC = 1'b0;
    localparam logic ID_DC = 1'b1;

    localparam int ADDR_W_DEF = 12;
    localparam int LINE_W_DEF = 128;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic (purely combinational).
// Ports:
//   req_ic, req_dc : pending requests
//   last_grant     : requester granted most recently (ID_IC / ID_DC)
//   grant_valid    : at least one request pending
//   grant_id       : requester to serve
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req_ic,
    input  logic req_dc,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = req_ic | req_dc;

    // On contention the requester that was not served last wins.
    always_comb begin
        if (req_ic && req_dc) begin
            grant_id = ~last_grant;
        end else if (req_dc) begin
            grant_id = ID_DC;
        end else begin
            grant_id = ID_IC;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache miss paths.
// A D-cache miss with a dirty victim writes the victim back before the refill.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrate and latch the winner's inputs
//   WB    | writing the latched victim line to memory (MEM_LAT cycles)
//   FILL  | reading the requested line from memory (MEM_LAT cycles)
//   RESP  | one-cycle ack to the granted requester
//
// Ports:
//   clk, reset (sync, active-low)
//   ic_req/ic_addr -> ic_ack/ic_data            : I-cache fill channel
//   dc_req/dc_addr/dc_wb/dc_wb_addr/dc_wb_data
//                  -> dc_ack/dc_data            : D-cache miss channel
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata : memory port
//   busy                                         : FSM not idle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_data,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_wb,
    input  logic [ADDR_W-1:0] dc_wb_addr,
    input  logic [LINE_W-1:0] dc_wb_data,
    output logic              dc_ack,
    output logic [LINE_W-1:0] dc_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  lat_cnt;
    logic              lat_done;
    logic              last_grant;
    logic              grant_id;
    logic              grant_valid;
    logic              gnt_id;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [LINE_W-1:0] wb_data_q;

    rr_arbiter2 u_rr (
        .req_ic      (ic_req),
        .req_dc      (dc_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (gnt_id)
    );

    assign lat_done = (lat_cnt == CNT_W'(MEM_LAT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            last_grant  <= ID_DC;
            grant_id    <= ID_IC;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            ic_data     <= '0;
            dc_data     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        grant_id   <= gnt_id;
                        last_grant <= gnt_id;
                        if (gnt_id == ID_DC) begin
                            fill_addr_q <= dc_addr;
                            wb_addr_q   <= dc_wb_addr;
                            wb_data_q   <= dc_wb_data;
                        end else begin
                            fill_addr_q <= ic_addr;
                        end
                    end
                end
                ST_WB: begin
                    lat_cnt <= lat_done ? '0 : lat_cnt + CNT_W'(1);
                end
                ST_FILL: begin
                    lat_cnt <= lat_done ? '0 : lat_cnt + CNT_W'(1);
                    // The per-requester data registers act as the line buffer;
                    // loading here makes them valid throughout the RESP cycle.
                    if (lat_done) begin
                        if (grant_id == ID_IC) begin
                            ic_data <= mem_rdata;
                        end else begin
                            dc_data <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ic_ack    = 1'b0;
        dc_ack    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_nxt = (gnt_id == ID_DC && dc_wb) ? ST_WB : ST_FILL;
                end
            end
            ST_WB: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (lat_done) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                mem_req = 1'b1;
                if (lat_done) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                ic_ack    = (grant_id == ID_IC);
                dc_ack    = (grant_id == ID_DC);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outside WB/FILL these simply keep showing the latched values.
    assign mem_addr  = (state == ST_WB) ? wb_addr_q : fill_addr_q;
    assign mem_wdata = wb_data_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 12;
    localparam int LW = 128;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req, dc_req, dc_wb;
    logic [AW-1:0] ic_addr, dc_addr, dc_wb_addr;
    logic [LW-1:0] dc_wb_data;
    logic          ic_ack, dc_ack, mem_req, mem_we, busy;
    logic [LW-1:0] ic_data, dc_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_data(ic_data),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_wb(dc_wb), .dc_wb_addr(dc_wb_addr),
        .dc_wb_data(dc_wb_data), .dc_ack(dc_ack), .dc_data(dc_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } mem_exp_t;

    typedef struct {
        int            cyc;
        logic          id;
        logic [LW-1:0] data;
    } ack_exp_t;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int rd_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] mem_model(input logic [AW-1:0] a);
        if (a == 12'h0A0) return 128'hDEAD_C0DE_0000_1111_2222_3333_4444_BEEF;
        return {a, ~a, 104'h5A_1234_5678_9ABC_DEF0_0F1E_2D3C};
    endfunction

    // Memory model: read data is only meaningful in the last cycle of a read burst.
    always @(posedge clk) rd_run <= (mem_req && !mem_we) ? rd_run + 1 : 0;
    always_comb begin
        mem_rdata = {4{32'hBAD0_BAD0}};
        if (mem_req && !mem_we && rd_run == LAT - 1) mem_rdata = mem_model(mem_addr);
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Queue the memory cycles and ack of one transaction granted in cycle c0.
    task automatic push_txn(input int c0, input logic id, input logic [AW-1:0] addr,
                            input logic wb, input logic [AW-1:0] wb_addr,
                            input logic [LW-1:0] wb_data, output int ack_cyc);
        int c;
        c = c0;
        if (wb) begin
            for (int i = 1; i <= LAT; i++) mem_q.push_back('{c0 + i, 1'b1, wb_addr, wb_data});
            c = c0 + LAT;
        end
        for (int i = 1; i <= LAT; i++) mem_q.push_back('{c + i, 1'b0, addr, '0});
        ack_cyc = c + LAT + 1;
        ack_q.push_back('{ack_cyc, id, mem_model(addr)});
    endtask

    // Monitor: compares every memory cycle and every ack against the scoreboard.
    always @(negedge clk) begin
        mem_exp_t me;
        ack_exp_t ae;
        if (!mem_req && mem_we) chk("mem_we_idle", mem_we, 1'b0);
        if (mem_req) begin
            if (mem_q.size() == 0) begin
                chk("mem_unexpected", mem_req, 1'b0);
            end else begin
                me = mem_q.pop_front();
                chk("mem_cycle", cyc, me.cyc);
                chk("mem_we", mem_we, me.we);
                chk("mem_addr", mem_addr, me.addr);
                if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
            end
        end
        if (ic_ack || dc_ack) begin
            chk("ack_exclusive", ic_ack & dc_ack, 1'b0);
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", ic_ack | dc_ack, 1'b0);
            end else begin
                ae = ack_q.pop_front();
                chk("ack_cycle", cyc, ae.cyc);
                chk("ack_id", dc_ack, ae.id);
                chk("ack_data", dc_ack ? dc_data : ic_data, ae.data);
            end
        end
    end

    initial begin
        int a, b, j, c;
        logic [LW-1:0] victim, victim2;
        victim  = 128'hC0FF_EE00_1122_3344_5566_7788_99AA_BBCC;
        victim2 = 128'h0BAD_F00D_CAFE_BABE_1357_2468_ACE0_BDF1;
        reset = 1'b0; ic_req = 1'b1; ic_addr = 12'h0A0;
        dc_req = 1'b0; dc_addr = '0; dc_wb = 1'b0; dc_wb_addr = '0; dc_wb_data = '0;

        // Reset held with ic_req active.
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_acks", {ic_ack, dc_ack}, 2'b00);
        chk("rst_ic_data", ic_data, '0);
        chk("rst_dc_data", dc_data, '0);
        chk("rst_busy", busy, 1'b0);

        // Clean IC fill granted right after release.
        reset = 1'b1;
        push_txn(cyc, ID_IC, 12'h0A0, 1'b0, '0, '0, a);
        wait_cyc(a); ic_req = 1'b0;
        wait_cyc(a + 1);
        chk("idle_after_ic", busy, 1'b0);

        // DC dirty miss: writeback then fill.
        j = cyc;
        dc_req = 1'b1; dc_wb = 1'b1; dc_wb_addr = 12'h011; dc_addr = 12'h022; dc_wb_data = victim;
        push_txn(j, ID_DC, 12'h022, 1'b1, 12'h011, victim, a);
        wait_cyc(a); dc_req = 1'b0; dc_wb = 1'b0;
        wait_cyc(a + 1);
        chk("idle_after_dc", busy, 1'b0);

        // Reset, then both requesters held: IC, DC, IC, DC.
        reset = 1'b0;
        wait_cyc(cyc + 1);
        reset = 1'b1;
        ic_req = 1'b1; ic_addr = 12'h100;
        dc_req = 1'b1; dc_addr = 12'h200; dc_wb = 1'b0; dc_wb_addr = 12'h7FF;
        c = cyc;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_txn(c, ID_IC, 12'h100, 1'b0, '0, '0, a);
            else            push_txn(c, ID_DC, 12'h200, 1'b0, '0, '0, a);
            c = a + 1;
        end
        wait_cyc(a); ic_req = 1'b0; dc_req = 1'b0;
        wait_cyc(a + 1);

        // DC request raised during an IC fill; its inputs change mid-writeback.
        j = cyc;
        ic_req = 1'b1; ic_addr = 12'h155;
        push_txn(j, ID_IC, 12'h155, 1'b0, '0, '0, a);
        wait_cyc(j + 2);
        dc_req = 1'b1; dc_addr = 12'h333; dc_wb = 1'b1; dc_wb_addr = 12'h044; dc_wb_data = victim2;
        push_txn(a + 1, ID_DC, 12'h333, 1'b1, 12'h044, victim2, b);
        wait_cyc(a); ic_req = 1'b0;
        wait_cyc(a + 3);
        dc_wb_data = ~victim2; dc_wb_addr = 12'h0FF; dc_addr = 12'h3FF;
        wait_cyc(b); dc_req = 1'b0; dc_wb = 1'b0;
        wait_cyc(b + 1);

        // Reset during the second FILL cycle abandons the access.
        j = cyc;
        ic_req = 1'b1; ic_addr = 12'h0A0;
        mem_q.push_back('{j + 1, 1'b0, 12'h0A0, '0});
        mem_q.push_back('{j + 2, 1'b0, 12'h0A0, '0});
        wait_cyc(j + 1);
        chk("busy_in_fill", busy, 1'b1);
        wait_cyc(j + 2);
        reset = 1'b0; ic_req = 1'b0;
        wait_cyc(j + 3);
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ic_data", ic_data, '0);
        reset = 1'b1;
        wait_cyc(j + 14);

        chk("mem_q_left", mem_q.size(), 0);
        chk("ack_q_left", ack_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_vec++; n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
